// File: rtl/perm_arbiter.sv
// perm_arbiter: two-requester round-robin front end for the perm core.
// Grants whole 8-beat blocks, spaces final beats, tags results with owner.
module perm_arbiter #(
  parameter int MIN_GAP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       rq_valid,
  input  logic [1:0][2:0]  rq_dix,
  input  logic [1:0][199:0] rq_din,
  output logic [1:0]       rq_ready,
  output logic             p_pushin,
  output logic [2:0]       p_dix,
  output logic [199:0]     p_din,
  input  logic             p_pushout,
  output logic             res_valid,
  output logic             res_owner,
  output logic             err_seq,
  output logic             err_orphan
);

  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [2:0]      exp_q, exp_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      fifo_q, fifo_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            p_pushin_q, p_pushin_d;
  logic [2:0]      p_dix_q, p_dix_d;
  logic [199:0]    p_din_q, p_din_d;
  logic            orphan_q, orphan_d;

  logic rdy, acc, hit, fin, pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      exp_q      <= 3'd0;
      gap_q      <= '0;
      fifo_q     <= 2'b00;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      p_pushin_q <= 1'b0;
      p_dix_q    <= 3'd0;
      p_din_q    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      exp_q      <= exp_d;
      gap_q      <= gap_d;
      fifo_q     <= fifo_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      p_pushin_q <= p_pushin_d;
      p_dix_q    <= p_dix_d;
      p_din_q    <= p_din_d;
      orphan_q   <= orphan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    exp_d   = exp_q;
    gap_d   = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    unique case (state_q)
      IDLE: begin
        if (|rq_valid) begin
          state_d = LOAD;
          grant_d = rq_valid[~last_q] ? ~last_q : rq_valid[1];
          exp_d   = 3'd0;
        end
      end
      LOAD: begin
        if (hit) exp_d = exp_q + 3'd1;
        if (fin) begin
          state_d = IDLE;
          gap_d   = GAP_LOAD;
          last_d  = grant_q;
        end
      end
      default: ;
    endcase
    // owner FIFO: push on final beat, pop on tracked result
    fifo_d = fifo_q;
    if (fin) fifo_d[wr_q] = grant_q;
    wr_d  = wr_q ^ fin;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, fin} - {1'b0, pop};
    p_pushin_d = hit;
    p_dix_d    = hit ? rq_dix[grant_q] : p_dix_q;
    p_din_d    = hit ? rq_din[grant_q] : p_din_q;
    orphan_d   = p_pushout & (cnt_q == 2'd0);
  end

  always_comb begin
    rdy = 1'b0;
    if (state_q == LOAD)
      rdy = (exp_q != 3'd7) || (gap_q == '0 && cnt_q != 2'd2);
    rq_ready          = 2'b00;
    rq_ready[grant_q] = rdy;
    acc       = rdy & rq_valid[grant_q];
    hit       = acc & (rq_dix[grant_q] == exp_q);
    fin       = hit & (exp_q == 3'd7);
    err_seq   = acc & ~hit;
    pop       = p_pushout & (cnt_q != 2'd0);
    res_valid = pop;
    res_owner = fifo_q[rd_q];
  end

  assign p_pushin   = p_pushin_q;
  assign p_dix      = p_dix_q;
  assign p_din      = p_din_q;
  assign err_orphan = orphan_q;

endmodule

// File: tb/tb_perm_arbiter.sv
// tb_perm_arbiter: directed tests for perm_arbiter.
// Second instance with MIN_GAP=12 exercises the final-beat throttle.
module tb_perm_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       rq_valid;
  logic [1:0][2:0]  rq_dix;
  logic [1:0][199:0] rq_din;
  logic             p_pushout;
  logic [1:0]       rq_ready;
  logic             p_pushin;
  logic [2:0]       p_dix;
  logic [199:0]     p_din;
  logic             res_valid, res_owner, err_seq, err_orphan;

  logic [1:0]       g_valid;
  logic [1:0][2:0]  g_dix;
  logic [1:0][199:0] g_din;
  logic             g_pushout;
  logic [1:0]       g_ready;
  logic             g_pushin;
  logic [2:0]       g_pdix;
  logic [199:0]     g_pdin;
  logic             g_res_valid, g_res_owner, g_err_seq, g_err_orphan;

  int checks = 0;
  int errors = 0;

  perm_arbiter #(.MIN_GAP(8)) dut (
    .clk(clk), .reset(reset),
    .rq_valid(rq_valid), .rq_dix(rq_dix), .rq_din(rq_din),
    .rq_ready(rq_ready),
    .p_pushin(p_pushin), .p_dix(p_dix), .p_din(p_din),
    .p_pushout(p_pushout),
    .res_valid(res_valid), .res_owner(res_owner),
    .err_seq(err_seq), .err_orphan(err_orphan)
  );

  perm_arbiter #(.MIN_GAP(12)) dut12 (
    .clk(clk), .reset(reset),
    .rq_valid(g_valid), .rq_dix(g_dix), .rq_din(g_din),
    .rq_ready(g_ready),
    .p_pushin(g_pushin), .p_dix(g_pdix), .p_din(g_pdin),
    .p_pushout(g_pushout),
    .res_valid(g_res_valid), .res_owner(g_res_owner),
    .err_seq(g_err_seq), .err_orphan(g_err_orphan)
  );

  function automatic logic [199:0] pay(input int d);
    return {25{8'(d + 17)}};
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    rq_valid = '0; rq_dix = '0; rq_din = '0; p_pushout = 1'b0;
    g_valid = '0; g_dix = '0; g_din = '0; g_pushout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rq_valid = 2'b11; g_valid = 2'b11;
    p_pushout = 1'b1; g_pushout = 1'b1;
    #1;
    checks++;
    if ({rq_ready, p_pushin, p_dix, p_din, res_valid, err_seq, err_orphan} !== '0) begin
      errors++;
      $display("FAIL reset_out8 got=%0h exp=0",
        {rq_ready, p_pushin, p_dix, res_valid, err_seq, err_orphan});
    end
    checks++;
    if ({g_ready, g_pushin, g_pdix, g_pdin, g_res_valid, g_err_seq, g_err_orphan} !== '0) begin
      errors++;
      $display("FAIL reset_out12 got=%0h exp=0",
        {g_ready, g_pushin, g_pdix, g_res_valid, g_err_seq, g_err_orphan});
    end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    rq_valid = 2'b01; rq_dix[0] = 3'd0; rq_din[0] = pay(0);
    #1;
    checks++;
    if (rq_ready !== 2'b00) begin
      errors++; $display("FAIL single_idle_ready got=%b exp=00", rq_ready);
    end
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      rq_dix[0] = 3'(d); rq_din[0] = pay(d);
      #1;
      checks++;
      if (rq_ready !== 2'b01) begin
        errors++; $display("FAIL single_ready d=%0d got=%b exp=01", d, rq_ready);
      end
      if (d > 0) begin
        checks++;
        if (p_pushin !== 1'b1 || p_dix !== 3'(d - 1)) begin
          errors++;
          $display("FAIL single_fwd got=%b/%0d exp=1/%0d", p_pushin, p_dix, d - 1);
        end
      end
    end
    @(negedge clk);
    rq_valid = 2'b00;
    #1;
    checks++;
    if (p_pushin !== 1'b1 || p_dix !== 3'd7 || p_din !== pay(7)) begin
      errors++; $display("FAIL single_last got=%b/%0d exp=1/7", p_pushin, p_dix);
    end
    checks++;
    if (rq_ready !== 2'b00) begin
      errors++; $display("FAIL single_after_ready got=%b exp=00", rq_ready);
    end
    @(negedge clk);
    p_pushout = 1'b1;
    #1;
    checks++;
    if (p_pushin !== 1'b0) begin
      errors++; $display("FAIL single_pushin_low got=%b exp=0", p_pushin);
    end
    checks++;
    if (res_valid !== 1'b1 || res_owner !== 1'b0) begin
      errors++; $display("FAIL single_res got=%b/%b exp=1/0", res_valid, res_owner);
    end
    @(negedge clk);
    p_pushout = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL single_orphan got=%b exp=0", err_orphan);
    end
  endtask

  task automatic test_rr;
    int blk, eo;
    int dx[2];
    logic pend, pown;
    do_reset();
    blk = 0; dx[0] = 0; dx[1] = 0; pend = 1'b0; pown = 1'b0;
    rq_valid = 2'b11;
    for (int c = 0; c < 60 && blk < 4; c++) begin
      @(negedge clk);
      p_pushout = pend;
      rq_dix[0] = 3'(dx[0]); rq_din[0] = pay(dx[0]);
      rq_dix[1] = 3'(dx[1]); rq_din[1] = pay(dx[1] + 8);
      #1;
      if (pend) begin
        checks++;
        if (res_valid !== 1'b1 || res_owner !== pown) begin
          errors++;
          $display("FAIL rr_res got=%b/%b exp=1/%b", res_valid, res_owner, pown);
        end
      end
      pend = 1'b0;
      eo = blk % 2;
      checks++;
      if (rq_ready[1 - eo] !== 1'b0) begin
        errors++; $display("FAIL rr_other_ready blk=%0d got=%b exp=0", blk, rq_ready);
      end
      if (rq_ready[eo]) begin
        if (dx[eo] == 7) begin
          pend = 1'b1; pown = 1'(eo); blk++;
        end
        dx[eo] = (dx[eo] + 1) % 8;
      end
    end
    @(negedge clk);
    rq_valid = 2'b00;
    p_pushout = pend;
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_owner !== 1'b1) begin
      errors++; $display("FAIL rr_last_res got=%b/%b exp=1/1", res_valid, res_owner);
    end
    checks++;
    if (blk !== 4) begin
      errors++; $display("FAIL rr_blocks got=%0d exp=4", blk);
    end
    @(negedge clk);
    p_pushout = 1'b0;
  endtask

  task automatic test_gap;
    int dx, fin_cnt, stall, fwd;
    int fa[2];
    int ff[2];
    do_reset();
    dx = 0; fin_cnt = 0; stall = 0; fwd = 0;
    fa[0] = 0; fa[1] = 0; ff[0] = 0; ff[1] = 0;
    g_valid = 2'b01;
    for (int c = 0; c < 50 && fwd < 2; c++) begin
      @(negedge clk);
      if (fin_cnt == 2) g_valid = 2'b00;
      g_dix[0] = 3'(dx); g_din[0] = pay(dx);
      #1;
      if (g_pushin && g_pdix == 3'd7) begin
        ff[fwd] = c; fwd++;
      end
      if (g_ready[0] && g_valid[0]) begin
        if (dx == 7) begin
          fa[fin_cnt] = c; fin_cnt++;
        end
        dx = (dx + 1) % 8;
      end else if (dx == 7) begin
        stall++;
      end
    end
    g_valid = 2'b00;
    checks++;
    if (stall !== 3) begin
      errors++; $display("FAIL gap_stall got=%0d exp=3", stall);
    end
    checks++;
    if (fa[1] - fa[0] !== 12) begin
      errors++; $display("FAIL gap_accept_dist got=%0d exp=12", fa[1] - fa[0]);
    end
    checks++;
    if (fwd !== 2 || ff[1] - ff[0] !== 12) begin
      errors++; $display("FAIL gap_fwd_dist got=%0d exp=12", ff[1] - ff[0]);
    end
  endtask

  task automatic test_seq;
    int sq[9] = '{0, 1, 3, 2, 3, 4, 5, 6, 7};
    int k;
    logic pf;
    logic [2:0] pd;
    do_reset();
    k = 0; pf = 1'b0; pd = 3'd0;
    rq_valid = 2'b10;
    for (int c = 0; c < 40 && k < 9; c++) begin
      @(negedge clk);
      rq_dix[1] = 3'(sq[k]); rq_din[1] = pay(sq[k]);
      #1;
      checks++;
      if (p_pushin !== pf || (pf && p_dix !== pd)) begin
        errors++;
        $display("FAIL seq_fwd got=%b/%0d exp=%b/%0d", p_pushin, p_dix, pf, pd);
      end
      if (rq_ready[1]) begin
        checks++;
        if (err_seq !== (k == 2)) begin
          errors++; $display("FAIL seq_err k=%0d got=%b exp=%b", k, err_seq, k == 2);
        end
        pf = (k != 2); pd = 3'(sq[k]); k++;
      end else begin
        checks++;
        if (err_seq !== 1'b0) begin
          errors++; $display("FAIL seq_err_idle got=%b exp=0", err_seq);
        end
        pf = 1'b0;
      end
    end
    @(negedge clk);
    rq_valid = 2'b00;
    p_pushout = 1'b1;
    #1;
    checks++;
    if (k !== 9 || p_pushin !== 1'b1 || p_dix !== 3'd7) begin
      errors++; $display("FAIL seq_done got=%0d/%b/%0d exp=9/1/7", k, p_pushin, p_dix);
    end
    checks++;
    if (res_valid !== 1'b1 || res_owner !== 1'b1) begin
      errors++; $display("FAIL seq_res got=%b/%b exp=1/1", res_valid, res_owner);
    end
    @(negedge clk);
    p_pushout = 1'b0;
  endtask

  task automatic test_fifo_full;
    int dx, blk, stall, cpop;
    logic popped;
    do_reset();
    dx = 0; blk = 0; stall = 0; cpop = -10; popped = 1'b0;
    rq_valid = 2'b01;
    for (int c = 0; c < 60 && blk < 3; c++) begin
      @(negedge clk);
      rq_dix[0] = 3'(dx); rq_din[0] = pay(dx);
      p_pushout = 1'b0;
      if (blk == 2 && dx == 7 && stall == 4 && !popped) p_pushout = 1'b1;
      #1;
      if (p_pushout) begin
        checks++;
        if (res_valid !== 1'b1 || res_owner !== 1'b0 || rq_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL full_pop got=%b/%b/%b exp=1/0/0", res_valid, res_owner, rq_ready[0]);
        end
        popped = 1'b1; cpop = c;
      end else if (rq_ready[0]) begin
        if (dx == 7) begin
          if (blk == 2) begin
            checks++;
            if (c !== cpop + 1) begin
              errors++; $display("FAIL full_release got=%0d exp=%0d", c, cpop + 1);
            end
          end
          blk++;
        end
        dx = (dx + 1) % 8;
      end else if (blk == 2 && dx == 7) begin
        stall++;
      end
    end
    @(negedge clk);
    rq_valid = 2'b00;
    p_pushout = 1'b1;
    #1;
    checks++;
    if (blk !== 3 || res_valid !== 1'b1 || res_owner !== 1'b0) begin
      errors++; $display("FAIL full_pop2 got=%0d/%b exp=3/1", blk, res_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_owner !== 1'b0) begin
      errors++; $display("FAIL full_pop3 got=%b/%b exp=1/0", res_valid, res_owner);
    end
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL full_empty got=%b exp=0", res_valid);
    end
    @(negedge clk);
    p_pushout = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL full_orphan got=%b exp=1", err_orphan);
    end
  endtask

  task automatic test_orphan;
    do_reset();
    p_pushout = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL orphan_res got=%b exp=0", res_valid);
    end
    @(negedge clk);
    p_pushout = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_pulse got=%b exp=1", err_orphan);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++; $display("FAIL orphan_one_cycle got=%b exp=0", err_orphan);
    end
  endtask

  task automatic test_async_reset;
    int dx;
    do_reset();
    dx = 0;
    rq_valid = 2'b01;
    for (int c = 0; c < 20 && dx < 4; c++) begin
      @(negedge clk);
      rq_dix[0] = 3'(dx); rq_din[0] = pay(dx);
      #1;
      if (rq_ready[0]) dx++;
    end
    @(negedge clk);
    rq_dix[0] = 3'd4; rq_din[0] = pay(4);
    #1;
    checks++;
    if (p_pushin !== 1'b1 || p_dix !== 3'd3) begin
      errors++; $display("FAIL arst_pre got=%b/%0d exp=1/3", p_pushin, p_dix);
    end
    #1;
    reset = 1'b1;
    rq_valid = 2'b11;
    #1;
    checks++;
    if ({rq_ready, p_pushin, p_dix, p_din, res_valid, err_seq, err_orphan} !== '0) begin
      errors++;
      $display("FAIL arst_out got=%0h exp=0",
        {rq_ready, p_pushin, p_dix, res_valid, err_seq, err_orphan});
    end
    @(negedge clk);
    reset = 1'b0;
    p_pushout = 1'b1;
    rq_dix[0] = 3'd4; rq_dix[1] = 3'd0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || rq_ready !== 2'b00) begin
      errors++; $display("FAIL arst_idle got=%b/%b exp=0/00", res_valid, rq_ready);
    end
    @(negedge clk);
    p_pushout = 1'b0;
    #1;
    checks++;
    if (rq_ready !== 2'b01 || err_seq !== 1'b1) begin
      errors++; $display("FAIL arst_regrant got=%b/%b exp=01/1", rq_ready, err_seq);
    end
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL arst_fifo_empty got=%b exp=1", err_orphan);
    end
    @(negedge clk);
    rq_dix[0] = 3'd0; rq_din[0] = pay(0);
    #1;
    checks++;
    if (p_pushin !== 1'b0 || err_seq !== 1'b0 || rq_ready !== 2'b01) begin
      errors++;
      $display("FAIL arst_restart got=%b/%b/%b exp=0/0/01", p_pushin, err_seq, rq_ready);
    end
    @(negedge clk);
    rq_valid = 2'b00;
    #1;
    checks++;
    if (p_pushin !== 1'b1 || p_dix !== 3'd0) begin
      errors++; $display("FAIL arst_fwd0 got=%b/%0d exp=1/0", p_pushin, p_dix);
    end
  endtask

  initial begin
    reset = 1'b0;
    rq_valid = '0; rq_dix = '0; rq_din = '0; p_pushout = 1'b0;
    g_valid = '0; g_dix = '0; g_din = '0; g_pushout = 1'b0;
    #2;
    test_reset();
    test_single();
    test_rr();
    test_gap();
    test_seq();
    test_fifo_full();
    test_orphan();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
